// File: rtl/rgbled_pwm_core_if.sv
// rgbled_pwm_core_if: configuration inputs and LED drive outputs of the RGB PWM core
interface rgbled_pwm_core_if #(
  parameter int PWM_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int BLINK_WIDTH    = 8
);
  logic                      ctrl_enable;
  logic                      ctrl_blink;
  logic [PRESCALE_WIDTH-1:0] cfg_prescale;
  logic [BLINK_WIDTH-1:0]    cfg_blink_periods;
  logic [PWM_WIDTH-1:0]      duty_r;
  logic [PWM_WIDTH-1:0]      duty_g;
  logic [PWM_WIDTH-1:0]      duty_b;
  logic                      cfg_update;
  logic                      led_r;
  logic                      led_g;
  logic                      led_b;
  logic                      period_tick;
  logic                      update_pending;
  modport master (
    output ctrl_enable, ctrl_blink, cfg_prescale, cfg_blink_periods,
    output duty_r, duty_g, duty_b, cfg_update,
    input  led_r, led_g, led_b, period_tick, update_pending
  );
  modport slave (
    input  ctrl_enable, ctrl_blink, cfg_prescale, cfg_blink_periods,
    input  duty_r, duty_g, duty_b, cfg_update,
    output led_r, led_g, led_b, period_tick, update_pending
  );
endinterface

// File: rtl/rgbled_pwm_core.sv
// rgbled_pwm_core: three-channel PWM with shadowed config applied at period wraps and blink gating
module rgbled_pwm_core #(
  parameter int PWM_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int BLINK_WIDTH    = 8
) (
  input logic              ACLK,
  input logic              ARESETN,
  rgbled_pwm_core_if.slave bus
);
  localparam logic [PWM_WIDTH-1:0] CNT_LAST = {{(PWM_WIDTH-1){1'b1}}, 1'b0};
  logic [PRESCALE_WIDTH-1:0] r_pc, r_sh_prescale;
  logic [PWM_WIDTH-1:0]      r_cnt, r_sh_r, r_sh_g, r_sh_b;
  logic [BLINK_WIDTH-1:0]    r_bc, r_sh_blink_periods;
  logic                      r_sh_blink, r_phase, r_pending, r_period_tick;
  logic [2:0]                r_led;
  logic                      w_en, w_tick, w_wrap, w_load, w_gate, w_bc_last;
  assign w_en      = bus.ctrl_enable;
  assign w_tick    = w_en && r_pc == r_sh_prescale;
  assign w_wrap    = w_tick && r_cnt == CNT_LAST;
  assign w_load    = w_en ? w_wrap && (r_pending || bus.cfg_update) : r_pending;
  assign w_gate    = w_en && (!r_sh_blink || r_phase);
  assign w_bc_last = r_bc == r_sh_blink_periods;
  // prescaler and period counter, parked at zero while disabled
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      r_pc  <= '0;
      r_cnt <= '0;
    end else begin
      r_pc  <= (!w_en || w_tick) ? '0 : r_pc + 1'b1;
      r_cnt <= (!w_en || w_wrap) ? '0 : r_cnt + PWM_WIDTH'(w_tick);
    end
  // blink period counter and on/off phase; phase rests on when blink is off
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      r_bc    <= '0;
      r_phase <= 1'b1;
    end else if (!w_en || !r_sh_blink) begin
      r_bc    <= '0;
      r_phase <= 1'b1;
    end else if (w_wrap) begin
      r_bc    <= w_bc_last ? '0 : r_bc + 1'b1;
      r_phase <= r_phase ^ w_bc_last;
    end
  // shadow registers, loaded at a wrap (or at once when disabled) so a period never mixes settings
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      r_pending          <= 1'b0;
      r_sh_prescale      <= '0;
      r_sh_blink_periods <= '0;
      r_sh_blink         <= 1'b0;
      r_sh_r             <= '0;
      r_sh_g             <= '0;
      r_sh_b             <= '0;
    end else begin
      r_pending <= !w_load && (r_pending || bus.cfg_update);
      if (w_load) begin
        r_sh_prescale      <= bus.cfg_prescale;
        r_sh_blink_periods <= bus.cfg_blink_periods;
        r_sh_blink         <= bus.ctrl_blink;
        r_sh_r             <= bus.duty_r;
        r_sh_g             <= bus.duty_g;
        r_sh_b             <= bus.duty_b;
      end
    end
  // registered LED compare and period strobe
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      r_led         <= '0;
      r_period_tick <= 1'b0;
    end else begin
      r_led         <= {3{w_gate}} & {r_cnt < r_sh_b, r_cnt < r_sh_g, r_cnt < r_sh_r};
      r_period_tick <= w_wrap;
    end
  assign bus.led_r          = r_led[0];
  assign bus.led_g          = r_led[1];
  assign bus.led_b          = r_led[2];
  assign bus.period_tick    = r_period_tick;
  assign bus.update_pending = r_pending;
endmodule

// File: tb/tb_rgbled_pwm_core.sv
// tb_rgbled_pwm_core: directed test-plan scenarios plus random traffic against a period-level model
module tb_rgbled_pwm_core;
  localparam int P = 255;
  logic ACLK = 1'b0;
  logic ARESETN = 1'b1;
  int n_chk = 0, n_pass = 0;
  bit mon = 0;
  rgbled_pwm_core_if #(.PWM_WIDTH(8), .PRESCALE_WIDTH(16), .BLINK_WIDTH(8)) bus ();
  rgbled_pwm_core #(.PWM_WIDTH(8), .PRESCALE_WIDTH(16), .BLINK_WIDTH(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus));
  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: position in the period is counted in raw clock cycles; the PWM step is that
  // position divided by the prescale ratio, and a period lasts 255 steps.
  int m_pre = 0, m_bp = 0, m_d[3] = '{0, 0, 0};
  bit m_blink = 0, m_phase = 1, m_pend = 0, m_pt = 0;
  bit m_led[3] = '{0, 0, 0};
  int m_e = 0, m_done = 0;
  int step_len, step;
  bit en, upd, wrap, ld;
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_pre = 0; m_bp = 0; m_d = '{0, 0, 0}; m_blink = 0; m_phase = 1; m_pend = 0;
      m_pt = 0; m_led = '{0, 0, 0}; m_e = 0; m_done = 0;
    end else begin
      en = bus.ctrl_enable;
      upd = bus.cfg_update;
      step_len = m_pre + 1;
      step = m_e / step_len;
      wrap = en && m_e == P * step_len - 1;
      for (int i = 0; i < 3; i++) m_led[i] = en && (!m_blink || m_phase) && step < m_d[i];
      m_pt = wrap;
      ld = en ? (wrap && (m_pend || upd)) : m_pend;
      if (!en || !m_blink) begin
        m_done = 0;
        m_phase = 1;
      end else if (wrap) begin
        m_done++;
        if (m_done > m_bp) begin
          m_done = 0;
          m_phase = !m_phase;
        end
      end
      m_e = (!en || wrap) ? 0 : m_e + 1;
      m_pend = !ld && (m_pend || upd);
      if (ld) begin
        m_pre = bus.cfg_prescale; m_bp = bus.cfg_blink_periods; m_blink = bus.ctrl_blink;
        m_d[0] = bus.duty_r; m_d[1] = bus.duty_g; m_d[2] = bus.duty_b;
      end
    end
    if (mon) begin
      #1;
      chk("led_r", bus.led_r, m_led[0]);
      chk("led_g", bus.led_g, m_led[1]);
      chk("led_b", bus.led_b, m_led[2]);
      chk("period_tick", bus.period_tick, m_pt);
      chk("update_pending", bus.update_pending, m_pend);
    end
  end

  task automatic sync_tick();
    int k = 0;
    do begin
      @(negedge ACLK);
      k++;
    end while (!bus.period_tick && k < 3000);
    chk("sync_tick_bound", int'(k < 3000), 1);
  endtask

  // One window = the samples for steps 0..254 of a period, ending on its period_tick.
  task automatic measure(input int upd_at, output int r, output int g, output int b,
                         output int n, output int pend);
    r = 0; g = 0; b = 0; n = 0; pend = -1;
    do begin
      @(negedge ACLK);
      bus.cfg_update = 1'b0;
      n++;
      r += int'(bus.led_r); g += int'(bus.led_g); b += int'(bus.led_b);
      if (n == upd_at + 1) pend = int'(bus.update_pending);
      if (n == upd_at) bus.cfg_update = 1'b1;
    end while (!bus.period_tick && n < 5000);
    chk("period_bound", int'(n < 5000), 1);
  endtask

  initial begin
    int r, g, b, n, pd, k;
    int blink_exp[4] = '{255, 255, 0, 0};
    bus.ctrl_enable = 0; bus.ctrl_blink = 0; bus.cfg_prescale = 0; bus.cfg_blink_periods = 0;
    bus.duty_r = 0; bus.duty_g = 0; bus.duty_b = 0; bus.cfg_update = 0;
    #3 ARESETN = 1'b0;
    mon = 1;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    // basic PWM: configure while disabled
    bus.duty_r = 64; bus.duty_g = 0; bus.duty_b = 255;
    bus.cfg_update = 1;
    @(negedge ACLK);
    bus.cfg_update = 0;
    chk("pend_disabled_set", bus.update_pending, 1);
    @(negedge ACLK);
    chk("pend_disabled_clr", bus.update_pending, 0);
    bus.ctrl_enable = 1;
    sync_tick();
    measure(-9, r, g, b, n, pd);
    chk("basic_len", n, 255); chk("basic_r", r, 64); chk("basic_g", g, 0); chk("basic_b", b, 255);
    // glitch-free update at step 10
    bus.duty_r = 200;
    measure(10, r, g, b, n, pd);
    chk("glitch_pend", pd, 1); chk("glitch_old_r", r, 64);
    chk("glitch_pend_clear", bus.update_pending, 0);
    measure(-9, r, g, b, n, pd);
    chk("glitch_new_r", r, 200);
    // prescaler
    bus.cfg_prescale = 3; bus.duty_g = 2;
    measure(5, r, g, b, n, pd);
    chk("pre_old_len", n, 255);
    measure(-9, r, g, b, n, pd);
    chk("pre_len", n, 1020); chk("pre_g", g, 8);
    // blink
    bus.cfg_prescale = 0; bus.duty_r = 255; bus.ctrl_blink = 1; bus.cfg_blink_periods = 1;
    measure(5, r, g, b, n, pd);
    for (int i = 0; i < 4; i++) begin
      measure(-9, r, g, b, n, pd);
      chk($sformatf("blink_r%0d", i), r, blink_exp[i]);
      chk($sformatf("blink_len%0d", i), n, 255);
    end
    // update coincident with a wrap
    bus.ctrl_blink = 0; bus.duty_r = 30;
    measure(254, r, g, b, n, pd);
    chk("coinc_pend", pd, 0);
    measure(-9, r, g, b, n, pd);
    chk("coinc_r", r, 30);
    // enable drop mid-period
    repeat (50) @(negedge ACLK);
    bus.ctrl_enable = 0;
    @(negedge ACLK);
    chk("drop_leds", int'({bus.led_r, bus.led_g, bus.led_b}), 0);
    repeat (3) @(negedge ACLK);
    bus.ctrl_enable = 1;
    // async reset while led_r is high
    k = 0;
    do begin
      @(negedge ACLK);
      k++;
    end while (!bus.led_r && k < 600);
    chk("led_r_high_bound", int'(k < 600), 1);
    #2 ARESETN = 1'b0;
    #1 chk("async_rst_leds", int'({bus.led_r, bus.led_g, bus.led_b}), 0);
    @(negedge ACLK);
    bus.ctrl_enable = 0;
    ARESETN = 1'b1;
    k = 0;
    repeat (5) begin
      @(negedge ACLK);
      k += int'(bus.led_r) + int'(bus.led_g) + int'(bus.led_b);
    end
    bus.ctrl_enable = 1;
    repeat (5) begin
      @(negedge ACLK);
      k += int'(bus.led_r) + int'(bus.led_g) + int'(bus.led_b);
    end
    chk("post_rst_leds", k, 0);
    // random traffic
    repeat (8000) begin
      @(negedge ACLK);
      bus.cfg_update = ($urandom_range(0, 99) == 0);
      if (bus.ctrl_enable ? $urandom_range(0, 399) == 0 : $urandom_range(0, 19) == 0)
        bus.ctrl_enable = !bus.ctrl_enable;
      if ($urandom_range(0, 49) == 0) begin
        bus.duty_r = $urandom_range(0, 2) == 0 ? 8'd255 : 8'($urandom);
        bus.duty_g = $urandom_range(0, 2) == 0 ? 8'd0 : 8'($urandom);
        bus.duty_b = 8'($urandom);
        bus.cfg_prescale = 16'($urandom_range(0, 1));
        bus.ctrl_blink = 1'($urandom);
        bus.cfg_blink_periods = 8'($urandom_range(0, 2));
      end
    end
    @(negedge ACLK);
    mon = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
